// File: rtl/sample_frame_tx.sv
// Frame buffer transmitter: fills FRAME_LEN samples, streams them on start, then idles GAP_LEN cycles.
// Optional frame counter output enabled by defining SAMPLE_FRAME_TX_FCNT_EN.
module sample_frame_tx #(
  parameter int FRAME_LEN = 10,
  parameter int GAP_LEN   = 4,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          start,
  output logic          en,
  output logic [DW-1:0] outp,
  output logic          busy,
  output logic          done
`ifdef SAMPLE_FRAME_TX_FCNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {FILL, READY, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic [DW-1:0] outp_q, outp_d;
  logic          buf_we;
  logic [DW-1:0] buf_q [FRAME_LEN];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    gap_cnt_d = gap_cnt_q;
    en_d      = 1'b0;
    done_d    = 1'b0;
    outp_d    = '0;
    buf_we    = 1'b0;
    case (state_q)
      FILL: begin
        if (ld_valid) begin
          buf_we = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = READY;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
      READY: begin
        // Launch sample 0 here so it is on the outputs the cycle after start
        if (start) begin
          state_d  = SEND;
          en_d     = 1'b1;
          outp_d   = buf_q[0];
          rd_ptr_d = PTR_ONE;
        end
      end
      SEND: begin
        if (done_q) begin
          rd_ptr_d  = '0;
          gap_cnt_d = '0;
          state_d   = (GAP_LEN == 0) ? FILL : GAP;
        end else begin
          en_d     = 1'b1;
          outp_d   = buf_q[rd_ptr_q];
          done_d   = (rd_ptr_q == LAST_IDX);
          rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_ONE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = FILL;
          wr_ptr_d  = '0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      gap_cnt_q <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      outp_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      en_q      <= en_d;
      done_q    <= done_d;
      outp_q    <= outp_d;
    end
  end

  // Sample storage is deliberately not reset; only a completed fill makes it visible
  always_ff @(posedge clk) begin
    if (buf_we && !rst) begin
      buf_q[wr_ptr_q] <= ld_data;
    end
  end

`ifdef SAMPLE_FRAME_TX_FCNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, done_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign en       = en_q;
  assign outp     = outp_q;
  assign done     = done_q;
  assign ld_ready = (state_q == FILL);
  assign busy     = (state_q == SEND) || (state_q == GAP);

endmodule

// File: tb/tb_sample_frame_tx.sv
// Directed self-checking bench for sample_frame_tx: default instance (10/4) plus a GAP_LEN=0 instance.
// Observed outputs are packed as {en, done, busy, ld_ready, outp} and compared with hand-computed vectors.
module tb_sample_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        ld_valid = 1'b0;
   logic [15:0] ld_data = '0;
   logic        start = 1'b0;
   logic        ld_ready, en, busy, done;
   logic [15:0] outp;

   logic        ld_valid_z = 1'b0;
   logic [15:0] ld_data_z = '0;
   logic        start_z = 1'b0;
   logic        ld_ready_z, en_z, busy_z, done_z;
   logic [15:0] outp_z;

`ifdef SAMPLE_FRAME_TX_FCNT_EN
   logic [15:0] frame_cnt, frame_cnt_z;
`endif

   int checks = 0;
   int errors = 0;

   sample_frame_tx #(.FRAME_LEN(10), .GAP_LEN(4), .DW(16)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .start(start), .en(en), .outp(outp), .busy(busy), .done(done)
`ifdef SAMPLE_FRAME_TX_FCNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   sample_frame_tx #(.FRAME_LEN(4), .GAP_LEN(0), .DW(16)) dut_z (
      .clk(clk), .rst(rst), .ld_valid(ld_valid_z), .ld_data(ld_data_z), .ld_ready(ld_ready_z),
      .start(start_z), .en(en_z), .outp(outp_z), .busy(busy_z), .done(done_z)
`ifdef SAMPLE_FRAME_TX_FCNT_EN
      , .frame_cnt(frame_cnt_z)
`endif
   );

   function automatic logic [19:0] pk(input logic e, input logic d, input logic b,
                                      input logic r, input logic [15:0] o);
      return {e, d, b, r, o};
   endfunction

   task automatic checkOutput(input string tag, input logic [19:0] obs, input logic [19:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s);
      ld_valid = v;
      ld_data  = d;
      start    = s;
      tick();
   endtask

   // Hard bound on the whole run so a stuck design still reports
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state of both instances
      rst = 1'b1;
      tick();
      checkOutput("reset", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));
      checkOutput("reset_z", {en_z, done_z, busy_z, ld_ready_z, outp_z}, pk(0, 0, 0, 1, 16'd0));
`ifdef SAMPLE_FRAME_TX_FCNT_EN
      checkOutput("fcnt_reset", {4'h0, frame_cnt}, 20'd0);
`endif
      rst = 1'b0;

      // Back-to-back load of 100..109, then one frame and the 4-cycle gap
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(100 + i), 1'b0);
      checkOutput("t1_ready", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 0, 16'd0));
      applyStimulus(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("t1_s%0d", i), {en, done, busy, ld_ready, outp},
                     pk(1, i == 9, 1, 0, 16'(100 + i)));
         applyStimulus(1'b0, 16'd0, 1'b0);
      end
      for (int g = 0; g < 4; g++) begin
         checkOutput($sformatf("t1_gap%0d", g), {en, done, busy, ld_ready, outp}, pk(0, 0, 1, 0, 16'd0));
         applyStimulus(1'b0, 16'd0, 1'b0);
      end
      checkOutput("t1_fill", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));

      // Load with idle cycles between samples; start during FILL is ignored
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 16'(200 + k), k < 2);
         checkOutput($sformatf("t2_fill%0d", k), {en, done, busy, ld_ready, outp},
                     pk(0, 0, 0, k != 9, 16'd0));
         if (k < 9) applyStimulus(1'b0, 16'hDEAD, k < 2);
      end
      // ld_valid while READY must not touch the buffer
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 16'hFFFF, 1'b0);
         checkOutput("t2_ready_hold", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 0, 16'd0));
      end
      applyStimulus(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("t2_s%0d", i), {en, done, busy, ld_ready, outp},
                     pk(1, i == 9, 1, 0, 16'(200 + i)));
         applyStimulus(1'b0, 16'd0, (i >= 2) && (i <= 5));
      end
      for (int g = 0; g < 4; g++) begin
         checkOutput($sformatf("t2_gap%0d", g), {en, done, busy, ld_ready, outp}, pk(0, 0, 1, 0, 16'd0));
         applyStimulus(1'b0, 16'd0, 1'b1);
      end
      checkOutput("t2_nostart_a", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));
      applyStimulus(1'b0, 16'd0, 1'b1);
      checkOutput("t2_nostart_b", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));
`ifdef SAMPLE_FRAME_TX_FCNT_EN
      checkOutput("fcnt_two", {4'h0, frame_cnt}, 20'd2);
`endif

      // Reset at the 5th sample abandons the frame; start afterwards produces nothing
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(300 + i), 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("t3_s%0d", i), {en, done, busy, ld_ready, outp},
                     pk(1, 0, 1, 0, 16'(300 + i)));
         if (i < 4) applyStimulus(1'b0, 16'd0, 1'b0);
      end
      rst = 1'b1;
      applyStimulus(1'b0, 16'd0, 1'b0);
      checkOutput("t3_rst", {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b0, 16'd0, 1'b1);
         checkOutput($sformatf("t3_idle%0d", j), {en, done, busy, ld_ready, outp}, pk(0, 0, 0, 1, 16'd0));
      end
      start = 1'b0;
`ifdef SAMPLE_FRAME_TX_FCNT_EN
      checkOutput("fcnt_after_rst", {4'h0, frame_cnt}, 20'd0);
`endif

      // GAP_LEN=0 instance with start held high across two frames
      start_z = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) begin
            ld_valid_z = 1'b1;
            ld_data_z  = 16'(10 * (f + 1) + i);
            tick();
         end
         ld_valid_z = 1'b0;
         tick();
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_f%0d_s%0d", f, i), {en_z, done_z, busy_z, ld_ready_z, outp_z},
                        pk(1, i == 3, 1, 0, 16'(10 * (f + 1) + i)));
            tick();
         end
         checkOutput($sformatf("t4_f%0d_end", f), {en_z, done_z, busy_z, ld_ready_z, outp_z},
                     pk(0, 0, 0, 1, 16'd0));
      end
      start_z = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_frame_tx.md
SAMPLE_FRAME_TX -- requirements
Module: sample_frame_tx

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 10, samples per frame (legal range 2..256).
REQ-002 SHALL have parameter GAP_LEN, default 4, idle cycles after each frame (legal range 0..255).
REQ-003 SHALL have parameter DW, default 16, sample width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ld_valid  input  1  load-side sample valid.
REQ-007 SHALL have port ld_data  input  DW  load-side sample.
REQ-008 SHALL have port ld_ready  output  1  buffer accepting samples.
REQ-009 SHALL have port start  input  1  request transmission of the buffered frame.
REQ-010 SHALL have port en  output  1  stream qualifier; high for exactly FRAME_LEN consecutive cycles per frame.
REQ-011 SHALL have port outp  output  DW  stream sample, valid when en=1.
REQ-012 SHALL have port busy  output  1  high in SEND and GAP.
REQ-013 SHALL have port done  output  1  one-cycle pulse coincident with the last sample of a frame.

Function
REQ-014 SHALL implement FSM states FILL, READY, SEND, GAP.
REQ-015 FILL: ld_ready=1; each cycle with ld_valid=1 SHALL write ld_data to buf[wr_ptr] and increment wr_ptr.
REQ-016 The write at wr_ptr=FRAME_LEN-1 SHALL move FILL->READY and clear wr_ptr; ld_ready SHALL be 0 in all other states.
REQ-017 ld_valid outside FILL SHALL be ignored, and the buffer SHALL NOT change.
REQ-018 start SHALL be ignored in FILL, SEND and GAP; no queuing.
REQ-019 READY with start=1 SHALL move to SEND; en=1 and outp=buf[0] appear on the next cycle (1-cycle latency).
REQ-020 SEND: en, outp and done SHALL be registered; outp=buf[rd_ptr], rd_ptr increments each cycle with no bubbles.
REQ-021 Sample rd_ptr=FRAME_LEN-1 SHALL assert done and move to GAP, or to FILL when GAP_LEN=0.
REQ-022 GAP: en=0, outp=0, for exactly GAP_LEN cycles, then FILL with wr_ptr=0.
REQ-023 When en=0, outp SHALL be driven to 0.
REQ-024 start held high continuously SHALL yield back-to-back frames, each separated by GAP_LEN idle cycles plus a full FILL.
REQ-025 A new frame SHALL fully overwrite the buffer; no residue from the previous frame is visible.

Reset
REQ-026 rst=1 SHALL force state=FILL, wr_ptr=0, rd_ptr=0, en=0, outp=0, done=0, busy=0, ld_ready=1 on the next edge.
REQ-027 rst SHALL take priority over every input in any state; rst during SEND SHALL drop en on the next edge and abandon the frame.
REQ-028 Buffer contents need not be reset; they SHALL never be emitted without a complete FILL.

Configuration
REQ-029 With macro SAMPLE_FRAME_TX_FCNT_EN defined, the block SHALL add output frame_cnt [15:0], which increments by 1 on each done pulse, wraps 65535->0, and resets to 0.
REQ-030 Without SAMPLE_FRAME_TX_FCNT_EN, the frame_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Load 100..109 one per cycle, then pulse start -> en=1 for 10 cycles, outp=100..109, done with 109, then 4 cycles en=0, then ld_ready=1.
REQ-032 Load with ld_valid gaps (every other cycle) -> READY is reached only after 10 accepted samples; the stream equals the accepted values in order.
REQ-033 start during FILL and during SEND -> no effect; exactly one frame is emitted; frame_cnt (when enabled) advances by exactly 1.
REQ-034 rst asserted at the 5th sample of SEND -> en=0 next cycle, ld_ready=1, and the subsequent start before a reload produces no output.
REQ-035 GAP_LEN=0, start held high, two frames loaded -> en falls exactly 1 cycle after done; ld_ready=1 immediately afterwards.
REQ-036 With SAMPLE_FRAME_TX_FCNT_EN, and frame_cnt preset by running 65536 frames (or forced) -> frame_cnt wraps to 0.
